vga_pattern_gen: RTL

//  Parametrised test-pattern generator on the VGA timing chain. Consumes the timing block's pixel

---
 rtl/vga_pattern_gen_pkg.sv | 34 +++
 rtl/vga_box_mover.sv | 117 +++++++++++
 rtl/vga_pattern_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern mode
// codes and the colour-bar lookup.
package vga_pattern_gen_pkg;

  // Pattern selection as presented on i_mode and held in the mode register.
  typedef enum logic [1:0] {
    MODE_BOX      = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_BOX_BARS = 2'd3
  } mode_e;

  localparam int NUM_BARS = 8;

  // Bar index to {R,G,B} on/off bits. Each bit is later widened so that a
  // channel is either all-zeros or all-ones.
  function automatic logic [2:0] barRgb(input logic [2:0] bar);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (bar)
      3'd0: rgb = 3'b111;
      3'd1: rgb = 3'b110;
      3'd2: rgb = 3'b011;
      3'd3: rgb = 3'b010;
      3'd4: rgb = 3'b101;
      3'd5: rgb = 3'b100;
      3'd6: rgb = 3'b001;
      3'd7: rgb = 3'b000;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker. The box moves by STEP pixels on both axes
// at every end-of-frame strobe, reverses direction when it would leave the
// active area, and is clamped to the edge it hit.
module vga_box_mover
  import vga_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int HW       = 10,
  parameter int VW       = 9,
  parameter int BOX_SIZE = 100,
  parameter int STEP     = 2,
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 100
) (
  input  logic          clk,
  input  logic          i_sclr,
  input  logic          i_eof,
  input  logic          i_pause,
  output logic [HW-1:0] o_boxX,
  output logic [VW-1:0] o_boxY
);

  // One extra bit on the comparisons so x+BOX_SIZE+STEP can never wrap.
  localparam int XW = HW + 1;
  localparam int YW = VW + 1;

  localparam logic [XW-1:0] X_REACH  = XW'(BOX_SIZE + STEP);
  localparam logic [XW-1:0] X_LIMIT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_STEPW  = XW'(STEP);
  localparam logic [HW-1:0] X_MAX    = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [HW-1:0] X_STEP   = HW'(STEP);
  localparam logic [HW-1:0] X_INIT   = HW'(INIT_X);

  localparam logic [YW-1:0] Y_REACH  = YW'(BOX_SIZE + STEP);
  localparam logic [YW-1:0] Y_LIMIT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_STEPW  = YW'(STEP);
  localparam logic [VW-1:0] Y_MAX    = VW'(V_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0] Y_STEP   = VW'(STEP);
  localparam logic [VW-1:0] Y_INIT   = VW'(INIT_Y);

  logic [HW-1:0] r_boxX;
  logic [VW-1:0] r_boxY;
  logic          r_dxNeg;
  logic          r_dyNeg;

  logic [HW-1:0] w_nextX;
  logic [VW-1:0] w_nextY;
  logic          w_nextDxNeg;
  logic          w_nextDyNeg;
  logic [XW-1:0] w_xExt;
  logic [YW-1:0] w_yExt;

  assign w_xExt = {1'b0, r_boxX};
  assign w_yExt = {1'b0, r_boxY};

  // Horizontal step with bounce: clamp to the far edge or to zero and flip.
  always_comb begin
    w_nextX     = r_boxX;
    w_nextDxNeg = r_dxNeg;
    if (!r_dxNeg) begin
      if (w_xExt + X_REACH > X_LIMIT) begin
        w_nextX     = X_MAX;
        w_nextDxNeg = 1'b1;
      end else begin
        w_nextX = r_boxX + X_STEP;
      end
    end else begin
      if (w_xExt < X_STEPW) begin
        w_nextX     = '0;
        w_nextDxNeg = 1'b0;
      end else begin
        w_nextX = r_boxX - X_STEP;
      end
    end
  end

  // Vertical step, same rules against the active line count.
  always_comb begin
    w_nextY     = r_boxY;
    w_nextDyNeg = r_dyNeg;
    if (!r_dyNeg) begin
      if (w_yExt + Y_REACH > Y_LIMIT) begin
        w_nextY     = Y_MAX;
        w_nextDyNeg = 1'b1;
      end else begin
        w_nextY = r_boxY + Y_STEP;
      end
    end else begin
      if (w_yExt < Y_STEPW) begin
        w_nextY     = '0;
        w_nextDyNeg = 1'b0;
      end else begin
        w_nextY = r_boxY - Y_STEP;
      end
    end
  end

  // Position only changes at end of frame so a frame is never torn.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_boxX  <= X_INIT;
      r_boxY  <= Y_INIT;
      r_dxNeg <= 1'b0;
      r_dyNeg <= 1'b0;
    end else if (i_eof && !i_pause) begin
      r_boxX  <= w_nextX;
      r_boxY  <= w_nextY;
      r_dxNeg <= w_nextDxNeg;
      r_dyNeg <= w_nextDyNeg;
    end
  end

  assign o_boxX = r_boxX;
  assign o_boxY = r_boxY;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: turns the timing chain's pixel coordinates
// into registered RGB for a bouncing box, colour bars, a checkerboard or
// the box drawn over the bars. Mode changes take effect at frame start.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int              H_ACTIVE  = 640,
  parameter int              V_ACTIVE  = 480,
  parameter int              HW        = 10,
  parameter int              VW        = 9,
  parameter int              CW        = 4,
  parameter int              BOX_SIZE  = 100,
  parameter int              STEP      = 2,
  parameter int              INIT_X    = 100,
  parameter int              INIT_Y    = 100,
  parameter logic [3*CW-1:0] FG_COLOR  = 12'hF00,
  parameter logic [3*CW-1:0] BG_COLOR  = 12'h00F,
  parameter int              CHK_SHIFT = 5
) (
  input  logic          clk,
  input  logic          i_sclr,
  input  logic          i_px_clk,
  input  logic          i_haddr_en,
  input  logic          i_vaddr_en,
  input  logic [HW-1:0] i_hidx,
  input  logic [VW-1:0] i_vidx,
  input  logic [1:0]    i_mode,
  input  logic          i_pause,
  output logic          o_de,
  output logic [CW-1:0] o_vga_red,
  output logic [CW-1:0] o_vga_green,
  output logic [CW-1:0] o_vga_blue
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int CNTW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int HW1   = HW + 1;
  localparam int VW1   = VW + 1;

  localparam logic [CNTW-1:0] BAR_LAST = CNTW'(BAR_W - 1);
  localparam logic [HW-1:0]   H_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0]   V_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [HW1-1:0]  BOX_W    = HW1'(BOX_SIZE);
  localparam logic [VW1-1:0]  BOX_H    = VW1'(BOX_SIZE);

  logic            w_act;
  logic            w_adv;
  logic            w_eof;
  logic [HW-1:0]   w_boxX;
  logic [VW-1:0]   w_boxY;
  logic [HW1-1:0]  w_hExt;
  logic [HW1-1:0]  w_boxXExt;
  logic [VW1-1:0]  w_vExt;
  logic [VW1-1:0]  w_boxYExt;
  logic            w_inBox;
  logic [CNTW-1:0] w_curCnt;
  logic [2:0]      w_curBar;
  logic [2:0]      w_barBits;
  logic [3*CW-1:0] w_barColor;
  logic            w_chkOdd;
  logic [3*CW-1:0] w_color;

  mode_e           r_mode;
  logic [CNTW-1:0] r_cnt;
  logic [2:0]      r_bar;
  logic            r_de;
  logic [3*CW-1:0] r_rgb;

  assign w_act = i_haddr_en & i_vaddr_en;
  assign w_adv = i_px_clk & w_act;
  assign w_eof = w_adv & (i_hidx == H_LAST) & (i_vidx == V_LAST);

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .HW       (HW),
    .VW       (VW),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP),
    .INIT_X   (INIT_X),
    .INIT_Y   (INIT_Y)
  ) u_boxMover (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_eof   (w_eof),
    .i_pause (i_pause),
    .o_boxX  (w_boxX),
    .o_boxY  (w_boxY)
  );

  // Half-open box test, widened so x+BOX_SIZE cannot wrap.
  assign w_hExt    = {1'b0, i_hidx};
  assign w_boxXExt = {1'b0, w_boxX};
  assign w_vExt    = {1'b0, i_vidx};
  assign w_boxYExt = {1'b0, w_boxY};
  assign w_inBox   = (w_hExt >= w_boxXExt) && (w_hExt < w_boxXExt + BOX_W) &&
                     (w_vExt >= w_boxYExt) && (w_vExt < w_boxYExt + BOX_H);

  // Column 0 restarts the bar walk so every line begins on bar 0.
  assign w_curCnt   = (i_hidx == '0) ? '0 : r_cnt;
  assign w_curBar   = (i_hidx == '0) ? 3'd0 : r_bar;
  assign w_barBits  = barRgb(w_curBar);
  assign w_barColor = {{CW{w_barBits[2]}}, {CW{w_barBits[1]}}, {CW{w_barBits[0]}}};

  assign w_chkOdd = i_hidx[CHK_SHIFT] ^ i_vidx[CHK_SHIFT];

  // Mode is latched at the last active pixel so it applies from the next (0,0).
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_mode <= MODE_BOX;
    end else if (w_eof) begin
      r_mode <= mode_e'(i_mode);
    end
  end

  // Bar walk: count pixels within a bar, step to the next bar, saturate at the last.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_cnt <= '0;
      r_bar <= 3'd0;
    end else if (w_adv) begin
      if (w_curCnt == BAR_LAST) begin
        r_cnt <= '0;
        r_bar <= (w_curBar == 3'd7) ? 3'd7 : w_curBar + 3'd1;
      end else begin
        r_cnt <= w_curCnt + CNTW'(1);
        r_bar <= w_curBar;
      end
    end
  end

  // Colour selection for the pixel currently presented.
  always_comb begin
    w_color = BG_COLOR;
    case (r_mode)
      MODE_BOX:      w_color = w_inBox ? FG_COLOR : BG_COLOR;
      MODE_BARS:     w_color = w_barColor;
      MODE_CHECKER:  w_color = w_chkOdd ? BG_COLOR : FG_COLOR;
      MODE_BOX_BARS: w_color = w_inBox ? FG_COLOR : w_barColor;
      default:       w_color = BG_COLOR;
    endcase
  end

  // Single output stage; blanking forces black and holds while the pixel enable is low.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else if (i_px_clk) begin
      r_de  <= w_act;
      r_rgb <= w_act ? w_color : '0;
    end
  end

  assign o_de        = r_de;
  assign o_vga_red   = r_rgb[3*CW-1:2*CW];
  assign o_vga_green = r_rgb[2*CW-1:CW];
  assign o_vga_blue  = r_rgb[CW-1:0];

endmodule
